// File: rtl/scb_pkg.sv
// Shared definitions for the issue scoreboard.
// Holds the opcode and FSM state enums, the register index width and the bit
// positions of the register fields inside the 32-bit instruction word.
package scb_pkg;

    localparam int unsigned REGW = 5;

    // Opcode field
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned OPC_W   = 5;

    // Register field LSB positions (each field is REGW bits wide)
    localparam int unsigned FLD_HI_LSB  = 20;  // [24:20]
    localparam int unsigned FLD_ADD_LSB = 18;  // [22:18], destination of ADD-class ops
    localparam int unsigned FLD_BR_LSB  = 13;  // [17:13], second source of BEQ
    localparam int unsigned FLD_MID_LSB = 9;   // [13:9]
    localparam int unsigned FLD_LO_LSB  = 0;   // [4:0]

    typedef enum logic [OPC_W-1:0] {
        OP_LV     = 5'd1,
        OP_ADD    = 5'd2,
        OP_ADD_3  = 5'd3,
        OP_ADD_4  = 5'd4,
        OP_ADD_5  = 5'd5,
        OP_CP     = 5'd6,
        OP_B      = 5'd7,
        OP_BEQ    = 5'd8,
        OP_SLR    = 5'd9,
        OP_GP     = 5'd10,
        OP_ADD_12 = 5'd12
    } opcode_e;

    typedef enum logic {
        RUN,
        BR_WAIT
    } state_e;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Bus bundle for the issue scoreboard.
// Fetch side : in_valid, in_instr, in_ready
// Decode side: issue_valid, issue_instr, issue_ready
// Write-back : wb_valid, wb_rd
// Control    : br_resolve, flush
// Monitor    : pending, stall_cycles
// The slave modport is the scoreboard view; master is the surrounding pipeline.
interface issue_scoreboard_if #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned REGW    = 5,
    parameter int unsigned STALL_W = 16
);
    logic               in_valid;
    logic [31:0]        in_instr;
    logic               in_ready;
    logic               issue_valid;
    logic [31:0]        issue_instr;
    logic               issue_ready;
    logic               wb_valid;
    logic [REGW-1:0]    wb_rd;
    logic               br_resolve;
    logic               flush;
    logic [NREG-1:0]    pending;
    logic [STALL_W-1:0] stall_cycles;

    modport slave (
        input  in_valid, in_instr, issue_ready, wb_valid, wb_rd, br_resolve, flush,
        output in_ready, issue_valid, issue_instr, pending, stall_cycles
    );

    modport master (
        output in_valid, in_instr, issue_ready, wb_valid, wb_rd, br_resolve, flush,
        input  in_ready, issue_valid, issue_instr, pending, stall_cycles
    );
endinterface

// File: rtl/scb_field_decode.sv
// Combinational register-field decoder for the issue scoreboard.
// instr_i     : instruction word, opcode in [31:27]
// rd_en_o/rd_o: destination register written by the instruction
// rs_en_o/rs_o: first source register
// rt_en_o/rt_o: second source register
// is_branch_o : opcode 7 or 8, issue must hold until the branch resolves
module scb_field_decode
    import scb_pkg::*;
(
    input  logic [31:0]     instr_i,
    output logic            rd_en_o,
    output logic [REGW-1:0] rd_o,
    output logic            rs_en_o,
    output logic [REGW-1:0] rs_o,
    output logic            rt_en_o,
    output logic [REGW-1:0] rt_o,
    output logic            is_branch_o
);
    logic [OPC_W-1:0] opcode;
    logic [REGW-1:0]  fld_hi, fld_add, fld_br, fld_mid, fld_lo;
    logic             unused_bits;

    assign opcode  = instr_i[OPC_LSB +: OPC_W];
    assign fld_hi  = instr_i[FLD_HI_LSB  +: REGW];
    assign fld_add = instr_i[FLD_ADD_LSB +: REGW];
    assign fld_br  = instr_i[FLD_BR_LSB  +: REGW];
    assign fld_mid = instr_i[FLD_MID_LSB +: REGW];
    assign fld_lo  = instr_i[FLD_LO_LSB  +: REGW];

    // Bits not covered by any register field in any format
    assign unused_bits = ^{instr_i[26:25], instr_i[8:5]};

    always_comb begin
        rd_en_o     = 1'b0;
        rd_o        = '0;
        rs_en_o     = 1'b0;
        rs_o        = '0;
        rt_en_o     = 1'b0;
        rt_o        = '0;
        is_branch_o = 1'b0;
        case (opcode)
            OP_ADD, OP_ADD_3, OP_ADD_4, OP_ADD_5, OP_ADD_12: begin
                rd_en_o = 1'b1;
                rd_o    = fld_add;
                rs_en_o = 1'b1;
                rs_o    = fld_mid;
                rt_en_o = 1'b1;
                rt_o    = fld_lo;
            end
            OP_LV: begin
                rd_en_o = 1'b1;
                rd_o    = fld_hi;
            end
            OP_CP: begin
                rd_en_o = 1'b1;
                rd_o    = fld_hi;
                rt_en_o = 1'b1;
                rt_o    = fld_lo;
            end
            OP_BEQ: begin
                rs_en_o     = 1'b1;
                rs_o        = fld_hi;
                rt_en_o     = 1'b1;
                rt_o        = fld_br;
                is_branch_o = 1'b1;
            end
            OP_B: begin
                is_branch_o = 1'b1;
            end
            OP_SLR: begin
                // Read-modify-write of the same register
                rd_en_o = 1'b1;
                rd_o    = fld_hi;
                rs_en_o = 1'b1;
                rs_o    = fld_hi;
                rt_en_o = 1'b1;
                rt_o    = fld_lo;
            end
            OP_GP: begin
                rt_en_o = 1'b1;
                rt_o    = fld_lo;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/issue_scoreboard.sv
// Issue controller between fetch and decode.
// Keeps a pending bit per architectural register for in-flight writes, stalls
// instructions with RAW/WAW hazards, holds issue after a branch until it
// resolves, and counts stall cycles (saturating).
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   bus          : issue_scoreboard_if slave (fetch, decode, write-back,
//                  branch/flush control, pending vector, stall counter)
// Build option SCB_WB_BYPASS_EN: a register being written back this cycle is
// treated as not pending, saving one stall cycle after write-back.
module issue_scoreboard #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned REGW    = scb_pkg::REGW,
    parameter int unsigned STALL_W = 16
) (
    input logic               clock,
    input logic               reset,
    issue_scoreboard_if.slave bus
);
    if (REGW != $clog2(NREG)) begin : g_bad_regw
        $error("REGW must equal clog2(NREG)");
    end

    scb_pkg::state_e state_q, state_d;
    logic               issue_valid_q, issue_valid_d;
    logic [31:0]        issue_instr_q, issue_instr_d;
    logic [NREG-1:0]    pending_q, pending_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic                    rd_en, rs_en, rt_en, is_branch;
    logic [scb_pkg::REGW-1:0] rd, rs, rt;
    logic [NREG-1:0]         wb_mask, pend_eff;
    logic                    hazard, in_ready, accept;

    scb_field_decode u_decode (
        .instr_i     (bus.in_instr),
        .rd_en_o     (rd_en),
        .rd_o        (rd),
        .rs_en_o     (rs_en),
        .rs_o        (rs),
        .rt_en_o     (rt_en),
        .rt_o        (rt),
        .is_branch_o (is_branch)
    );

    always_comb begin
        wb_mask = '0;
        if (bus.wb_valid) begin
            wb_mask[bus.wb_rd] = 1'b1;
        end
    end

`ifdef SCB_WB_BYPASS_EN
    assign pend_eff = pending_q & ~wb_mask;
`else
    assign pend_eff = pending_q;
`endif

    assign hazard = (rs_en && pend_eff[rs]) || (rt_en && pend_eff[rt]) ||
                    (rd_en && pend_eff[rd]);

    // FSM next state and handshake
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            scb_pkg::RUN: begin
                in_ready = (!issue_valid_q || bus.issue_ready) && !hazard && !bus.flush;
                if (bus.in_valid && in_ready && is_branch) begin
                    state_d = scb_pkg::BR_WAIT;
                end
            end
            scb_pkg::BR_WAIT: begin
                if (bus.br_resolve || bus.flush) begin
                    state_d = scb_pkg::RUN;
                end
            end
            default: state_d = scb_pkg::RUN;
        endcase
    end

    assign accept = bus.in_valid && in_ready;

    // Issue slot, scoreboard and stall counter
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_instr_d = issue_instr_q;
        if (accept) begin
            issue_valid_d = 1'b1;
            issue_instr_d = bus.in_instr;
        end else if (bus.flush) begin
            issue_valid_d = 1'b0;
        end else if (issue_valid_q && bus.issue_ready) begin
            issue_valid_d = 1'b0;
        end

        // Clear first so a same-cycle set of the same bit wins
        pending_d = pending_q & ~wb_mask;
        if (accept && rd_en) begin
            pending_d[rd] = 1'b1;
        end

        stall_d = stall_q;
        if (bus.in_valid && !in_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= scb_pkg::RUN;
            issue_valid_q <= 1'b0;
            issue_instr_q <= '0;
            pending_q     <= '0;
            stall_q       <= '0;
        end else begin
            state_q       <= state_d;
            issue_valid_q <= issue_valid_d;
            issue_instr_q <= issue_instr_d;
            pending_q     <= pending_d;
            stall_q       <= stall_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_instr  = issue_instr_q;
    assign bus.pending      = pending_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a vector table for hazard/decode
// behaviour plus hand-written sequences for branch wait, flush and async reset.
module tb_issue_scoreboard;

`ifdef SCB_WB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   st;

    issue_scoreboard_if #(.NREG(32), .REGW(5), .STALL_W(16)) bus ();

    issue_scoreboard #(.NREG(32), .REGW(5), .STALL_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        in_valid;
        logic [31:0] instr;
        logic        issue_ready;
        logic        wb_valid;
        logic [4:0]  wb_rd;
        logic        br;
        logic        fl;
        logic        exp_rdy;
        logic        exp_iv;
        logic [31:0] exp_instr;
        logic [31:0] exp_pend;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] f_add(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        logic [31:0] w;
        w        = '0;
        w[31:27] = op;
        w[22:18] = rd;
        w[13:9]  = rs;
        w[4:0]   = rt;
        return w;
    endfunction

    function automatic logic [31:0] f_w(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rt);
        logic [31:0] w;
        w        = '0;
        w[31:27] = op;
        w[24:20] = rd;
        w[4:0]   = rt;
        return w;
    endfunction

    function automatic logic [31:0] f_beq(input logic [4:0] rs, input logic [4:0] rt);
        logic [31:0] w;
        w        = '0;
        w[31:27] = 5'd8;
        w[24:20] = rs;
        w[17:13] = rt;
        return w;
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] ins, input logic ir,
                                 input logic wbv, input logic [4:0] wbr, input logic br,
                                 input logic fl, input logic rdy, input logic iv,
                                 input logic [31:0] einstr, input logic [31:0] pend,
                                 input int stall);
        vec_t r;
        r.in_valid    = v;
        r.instr       = ins;
        r.issue_ready = ir;
        r.wb_valid    = wbv;
        r.wb_rd       = wbr;
        r.br          = br;
        r.fl          = fl;
        r.exp_rdy     = rdy;
        r.exp_iv      = iv;
        r.exp_instr   = einstr;
        r.exp_pend    = pend;
        r.exp_stall   = 16'(stall);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; drives a cycle, checks in_ready mid-cycle and
    // registered outputs just after the next rising edge.
    task automatic apply(input string tag, input vec_t v);
        bus.in_valid    = v.in_valid;
        bus.in_instr    = v.instr;
        bus.issue_ready = v.issue_ready;
        bus.wb_valid    = v.wb_valid;
        bus.wb_rd       = v.wb_rd;
        bus.br_resolve  = v.br;
        bus.flush       = v.fl;
        #3;
        chk({tag, " in_ready"}, {31'b0, bus.in_ready}, {31'b0, v.exp_rdy});
        @(posedge clock);
        #1;
        chk({tag, " issue_valid"}, {31'b0, bus.issue_valid}, {31'b0, v.exp_iv});
        chk({tag, " issue_instr"}, bus.issue_instr, v.exp_instr);
        chk({tag, " pending"}, bus.pending, v.exp_pend);
        chk({tag, " stall_cycles"}, {16'b0, bus.stall_cycles}, {16'b0, v.exp_stall});
    endtask

    initial begin
        logic [31:0] a1, a2, l5a, l5b, l7, lv9, beq, nop, br7, lv6, lv4, lv5, lv7x;
        int          s;

        n_checks = 0;
        n_fail   = 0;
        s        = 3 - BYP;

        a1   = f_add(5'd2, 5'd3, 5'd1, 5'd2);
        a2   = f_add(5'd3, 5'd4, 5'd3, 5'd0);
        l5a  = f_w(5'd1, 5'd5, 5'd0);
        l5b  = f_w(5'd1, 5'd5, 5'd9);
        l7   = f_w(5'd1, 5'd7, 5'd0);
        lv9  = f_w(5'd1, 5'd9, 5'd0);
        beq  = f_beq(5'd1, 5'd2);
        nop  = 32'h0000_0123;
        br7  = 32'h3800_0000;
        lv6  = f_w(5'd1, 5'd6, 5'd0);
        lv4  = f_w(5'd1, 5'd4, 5'd0);
        lv5  = f_w(5'd1, 5'd5, 5'd0);
        lv7x = f_w(5'd1, 5'd7, 5'd0);

        //          v  instr  ir wbv rd br fl  rdy iv  instr  pend  stall
        // RAW on r3
        tbl.push_back(mkv(1, a1, 1, 0, 0, 0, 0, 1, 1, a1, 32'h8, 0));
        tbl.push_back(mkv(1, a2, 1, 0, 0, 0, 0, 0, 0, a1, 32'h8, 1));
        tbl.push_back(mkv(1, a2, 1, 0, 0, 0, 0, 0, 0, a1, 32'h8, 2));
`ifdef SCB_WB_BYPASS_EN
        tbl.push_back(mkv(1, a2, 1, 1, 3, 0, 0, 1, 1, a2, 32'h10, 2));
        tbl.push_back(mkv(0, 0,  1, 0, 0, 0, 0, 1, 0, a2, 32'h10, 2));
`else
        tbl.push_back(mkv(1, a2, 1, 1, 3, 0, 0, 0, 0, a1, 32'h0, 3));
        tbl.push_back(mkv(1, a2, 1, 0, 0, 0, 0, 1, 1, a2, 32'h10, 3));
`endif
        tbl.push_back(mkv(0, 0, 1, 1, 4, 0, 0, 1, 0, a2, 32'h0, s));
        // WAW on r5, with backpressure
        tbl.push_back(mkv(1, l5a, 1, 0, 0, 0, 0, 1, 1, l5a, 32'h20, s));
        tbl.push_back(mkv(1, l5b, 0, 0, 0, 0, 0, 0, 1, l5a, 32'h20, s + 1));
        tbl.push_back(mkv(1, l5b, 1, 0, 0, 0, 0, 0, 0, l5a, 32'h20, s + 2));
        tbl.push_back(mkv(0, 0,   1, 1, 5, 0, 0, 1, 0, l5a, 32'h0, s + 2));
        tbl.push_back(mkv(1, l5b, 1, 0, 0, 0, 0, 1, 1, l5b, 32'h20, s + 2));
        // Set/clear collision on r7
        tbl.push_back(mkv(1, l7, 1, 1, 7, 0, 0, 1, 1, l7, 32'hA0, s + 2));
        tbl.push_back(mkv(0, 0,  1, 1, 5, 0, 0, 1, 0, l7, 32'h80, s + 2));
        tbl.push_back(mkv(0, 0,  1, 1, 7, 0, 0, 1, 0, l7, 32'h0, s + 2));
        // Decode probes against pending r9 (in_valid low: no accept, no stall)
        tbl.push_back(mkv(1, lv9, 1, 0, 0, 0, 0, 1, 1, lv9, 32'h200, s + 2));
        tbl.push_back(mkv(0, f_w(5'd10, 5'd0, 5'd9),       1, 0, 0, 0, 0, 0, 0, lv9, 32'h200, s + 2));
        tbl.push_back(mkv(0, f_w(5'd9, 5'd9, 5'd0),        1, 0, 0, 0, 0, 0, 0, lv9, 32'h200, s + 2));
        tbl.push_back(mkv(0, f_w(5'd6, 5'd3, 5'd9),        1, 0, 0, 0, 0, 0, 0, lv9, 32'h200, s + 2));
        tbl.push_back(mkv(0, f_add(5'd12, 5'd1, 5'd9, 5'd0), 1, 0, 0, 0, 0, 0, 0, lv9, 32'h200, s + 2));
        tbl.push_back(mkv(0, f_add(5'd4, 5'd2, 5'd0, 5'd9),  1, 0, 0, 0, 0, 0, 0, lv9, 32'h200, s + 2));
        tbl.push_back(mkv(0, f_add(5'd5, 5'd9, 5'd0, 5'd0),  1, 0, 0, 0, 0, 0, 0, lv9, 32'h200, s + 2));
        tbl.push_back(mkv(0, f_add(5'd11, 5'd9, 5'd9, 5'd9), 1, 0, 0, 0, 0, 1, 0, lv9, 32'h200, s + 2));
        tbl.push_back(mkv(0, f_beq(5'd1, 5'd9),            1, 0, 0, 0, 0, 0, 0, lv9, 32'h200, s + 2));
        tbl.push_back(mkv(0, f_w(5'd1, 5'd3, 5'd9),        1, 0, 0, 0, 0, 1, 0, lv9, 32'h200, s + 2));
        tbl.push_back(mkv(0, 0, 1, 1, 9, 0, 0, 1, 0, lv9, 32'h0, s + 2));
        // Branch accepted, enters BR_WAIT
        tbl.push_back(mkv(1, beq, 1, 0, 0, 0, 0, 1, 1, beq, 32'h0, s + 2));

        // Reset
        bus.in_valid    = 1'b0;
        bus.in_instr    = '0;
        bus.issue_ready = 1'b1;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        bus.br_resolve  = 1'b0;
        bus.flush       = 1'b0;
        reset           = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("reset issue_valid", {31'b0, bus.issue_valid}, 32'd0);
        chk("reset issue_instr", bus.issue_instr, 32'd0);
        chk("reset pending", bus.pending, 32'd0);
        chk("reset stall_cycles", {16'b0, bus.stall_cycles}, 32'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Branch wait: ten held cycles, resolve, then accept
        st = s + 2;
        for (int i = 0; i < 10; i++) begin
            st++;
            apply($sformatf("brwait%0d", i), mkv(1, nop, 1, 0, 0, 0, 0, 0, 0, beq, 0, st));
        end
        st++;
        apply("br_resolve", mkv(1, nop, 1, 0, 0, 1, 0, 0, 0, beq, 0, st));
        apply("br_after", mkv(1, nop, 1, 0, 0, 0, 0, 1, 1, nop, 0, st));
        apply("br_in_run", mkv(0, 0, 1, 0, 0, 1, 0, 1, 0, nop, 0, st));
        apply("br_in_run2", mkv(0, 0, 1, 0, 0, 0, 0, 1, 0, nop, 0, st));

        // Flush out of BR_WAIT with a held issue slot
        apply("fl_lv6", mkv(1, lv6, 1, 0, 0, 0, 0, 1, 1, lv6, 32'h40, st));
        apply("fl_b", mkv(1, br7, 1, 0, 0, 0, 0, 1, 1, br7, 32'h40, st));
        st++;
        apply("fl_hold", mkv(1, nop, 0, 0, 0, 0, 0, 0, 1, br7, 32'h40, st));
        apply("fl_pulse", mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, br7, 32'h40, st));
        apply("fl_after", mkv(1, nop, 1, 0, 0, 0, 0, 1, 1, nop, 32'h40, st));

        // Async reset in BR_WAIT with pending = 0xF0
        apply("rs_lv4", mkv(1, lv4, 1, 0, 0, 0, 0, 1, 1, lv4, 32'h50, st));
        apply("rs_lv5", mkv(1, lv5, 1, 0, 0, 0, 0, 1, 1, lv5, 32'h70, st));
        apply("rs_lv7", mkv(1, lv7x, 1, 0, 0, 0, 0, 1, 1, lv7x, 32'hF0, st));
        apply("rs_beq", mkv(1, beq, 1, 0, 0, 0, 0, 1, 1, beq, 32'hF0, st));
        st++;
        apply("rs_wait", mkv(1, nop, 1, 0, 0, 0, 0, 0, 0, beq, 32'hF0, st));
        #1;
        reset = 1'b1;
        #1;
        chk("async in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("async issue_valid", {31'b0, bus.issue_valid}, 32'd0);
        chk("async issue_instr", bus.issue_instr, 32'd0);
        chk("async pending", bus.pending, 32'd0);
        chk("async stall_cycles", {16'b0, bus.stall_cycles}, 32'd0);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("post reset accept", {31'b0, bus.issue_valid}, 32'd1);
        chk("post reset instr", bus.issue_instr, nop);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller placed between instruction fetch and the decode/register-file stage.
- Tracks in-flight register writes with a per-register pending bit and stalls any instruction that has a RAW or WAW hazard.
- Holds issue after branches (opcodes 7, 8) until the branch resolves.
- Counts stall cycles for performance monitoring.

Parameters:
- NREG, 32, number of architectural registers; the pending vector is NREG bits wide.
- REGW, 5, register index width; must equal clog2(NREG).
- STALL_W, 16, width of the saturating stall counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  32  instruction word; opcode is in_instr[31:27].
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
- issue_valid  out  1  registered instruction available to decode.
- issue_instr  out  32  registered copy of the accepted instruction.
- issue_ready  in  1  decode consumes issue_instr when issue_valid && issue_ready.
- wb_valid  in  1  write-back is retiring a register write this cycle.
- wb_rd  in  REGW  register being written back.
- br_resolve  in  1  one-cycle pulse: the outstanding branch has resolved.
- flush  in  1  one-cycle pulse: discard the issue slot and any branch wait.
- pending  out  NREG  current scoreboard vector.
- stall_cycles  out  STALL_W  saturating count of cycles with in_valid && !in_ready.

Behaviour:
- Field extraction; register fields use the low REGW bits:
  - Opcodes 2, 3, 4, 5, 12: write [22:18]; read [13:9] and [4:0].
  - Opcode 1: write [24:20]; no reads.
  - Opcode 6: write [24:20]; read [4:0].
  - Opcode 8: read [24:20] and [17:13]; no write; branch.
  - Opcode 7: no reads, no write; branch.
  - Opcode 9: write [24:20]; read [24:20] and [4:0].
  - Opcode 10: read [4:0]; no write.
  - All other opcodes: no dependencies, no write.
- Hazard:
  - Asserted if any read register has its pending bit set (RAW), or if the write register has its pending bit set (WAW).
  - Bit 0 has no special treatment.
- FSM states:
  - RUN:
    - in_ready = (!issue_valid || issue_ready) && !hazard && !flush.
    - Accepting opcode 7 or 8 moves to BR_WAIT on the next edge.
  - BR_WAIT:
    - in_ready = 0.
    - br_resolve or flush returns to RUN on the next edge.
    - br_resolve while in RUN is ignored.
- Accept (in_valid && in_ready):
  - issue_instr <= in_instr and issue_valid <= 1 on the next edge (latency 1).
  - The write register's pending bit is set on the same edge.
- Issue slot:
  - issue_valid clears on consume when no new accept occurs in the same cycle.
  - flush clears issue_valid and forces BR_WAIT to RUN.
  - flush does not clear pending bits, because in-flight writes still retire.
- Scoreboard updates:
  - wb_valid clears pending[wb_rd].
  - Simultaneous set and clear of the same bit: set wins (a new writer is in flight).
- stall_cycles: +1 each cycle in_valid && !in_ready; saturates at all-ones.
- Reset values:
  - issue_valid = 0, issue_instr = 0, pending = 0, stall_cycles = 0, state = RUN.
  - in_ready follows from these values combinationally.
- Reset mid-operation discards the in-flight branch wait and all pending bits.

Optional Feature:
- Macro: SCB_WB_BYPASS_EN.
- Defined: a source or destination whose pending bit is being cleared by wb_valid in the same cycle is treated as not pending, so issue proceeds that cycle.
- Undefined: hazard uses only the registered pending vector, which adds one stall cycle after write-back.

Decomposition:
- Package scb_pkg holds:
  - the opcode enum (LV=1, ADD-class 2..5 and 12, CP=6, B=7, BEQ=8, SLR=9, GP=10);
  - the state enum {RUN, BR_WAIT};
  - REGW and the field bit-position constants.
- One sub-module, scb_field_decode: purely combinational; in_instr -> rd_en, rd, rs_en, rs, rt_en, rt, is_branch.

Test Plan:
- RAW:
  - Issue ADD (op 2) writing r3; next, ADD reading r3 with no wb -> in_ready=0, stall_cycles increments each cycle.
  - Pulse wb_valid with wb_rd=3 -> accepted next cycle; with SCB_WB_BYPASS_EN, accepted in the wb cycle.
- WAW:
  - LV to r5, then LV to r5 -> second held until wb_rd=5; pending[5] is 1 again after the second accept.
- Branch:
  - BEQ accepted -> in_ready=0 for 10 cycles; br_resolve pulse -> RUN, next instruction accepted one cycle later.
- Flush:
  - issue_valid=1 and BR_WAIT, pulse flush -> issue_valid=0, state RUN, pending unchanged.
- Backpressure:
  - issue_ready=0 with issue_valid=1 -> in_ready=0 and issue_instr stable.
  - Set/clear collision on r7 in the same cycle -> pending[7]=1.
- Reset:
  - Assert reset asynchronously mid-BR_WAIT with pending=0x0000_00F0 -> outputs cleared immediately, without waiting for a clock edge.
